// File: rtl/co_sequencer_if.sv
// Host-side instruction port of the coprocessor sequencer.
// Valid/ready handshake carrying 64-bit coprocessor instruction words.
interface co_sequencer_if;
    logic [63:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output instr_in,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr_in,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/co_sequencer.sv
// Instruction sequencer: FIFO-buffers host words and holds each on proc_out for its unit latency.
// Optional RAW hazard bubble between dependent words: define CO_SEQ_HAZARD_EN.
module co_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    co_sequencer_if.slave                host,
    output logic [63:0]                  proc_out,
    output logic                         issue,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int MAXL = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int LW   = $clog2(MAXL + 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    state_t         state;
    logic [63:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [LW-1:0]  cnt;
    logic [63:0]    head;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           hazard;

    function automatic logic [LW-1:0] hold_len(input logic [2:0] op);
        logic [LW-1:0] r;
        r = LW'(ADD_LAT - 1);
        unique case (1'b1)
            (op == 3'b000):                  r = '0;
            (op inside {3'b101, 3'b110, 3'b111}): r = LW'(MUL_LAT - 1);
            default:                         r = LW'(ADD_LAT - 1);
        endcase
        return r;
    endfunction

    assign full             = (count == CW'(DEPTH));
    assign empty            = (count == '0);
    assign host.instr_ready = !full && !rst;
    assign push             = host.instr_valid && host.instr_ready;
    assign head             = mem[rd_ptr];
    assign fifo_count       = count;
    assign busy             = !empty || (state != IDLE);

`ifdef CO_SEQ_HAZARD_EN
    logic [14:0] prev_adw;
    logic        prev_wr;

    // Six read-address fields sit contiguously in [38:9]; AdW is [53:39].
    always_comb begin
        hazard = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 3; w++) begin
                if (prev_wr && head[9+5*r +: 5] == prev_adw[5*w +: 5])
                    hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_adw <= '0;
            prev_wr  <= 1'b0;
        end else if (pop) begin
            prev_adw <= head[53:39];
            prev_wr  <= |head[2:0];
        end else if (state == HOLD && cnt == '0 && empty) begin
            prev_adw <= '0;
            prev_wr  <= 1'b0;
        end
    end
`else
    assign hazard = 1'b0;
`endif

    always_comb begin
        pop = 1'b0;
        unique case (state)
            IDLE:    pop = !empty;
            HOLD:    pop = (cnt == '0) && !empty && !hazard;
            GAP:     pop = !empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= host.instr_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= IDLE;
            cnt      <= '0;
            proc_out <= '0;
            issue    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            issue <= pop;

            if (pop) begin
                proc_out <= head;
                cnt      <= hold_len(head[2:0]);
                state    <= HOLD;
            end else begin
                unique case (state)
                    IDLE: begin
                        proc_out <= '0;
                    end
                    HOLD: begin
                        if (cnt != '0) begin
                            cnt <= cnt - LW'(1);
                        end else if (hazard && !empty) begin
                            proc_out <= '0;
                            state    <= GAP;
                        end else begin
                            proc_out <= '0;
                            state    <= IDLE;
                        end
                    end
                    GAP: begin
                        proc_out <= '0;
                        state    <= IDLE;
                    end
                    default: begin
                        proc_out <= '0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_co_sequencer.sv
// Directed self-checking bench for co_sequencer (DEPTH=4, ADD_LAT=1, MUL_LAT=4).
// Expected hazard behaviour follows CO_SEQ_HAZARD_EN.
module tb_co_sequencer;

    logic        clk;
    logic        rst;
    logic [63:0] proc_out;
    logic        issue;
    logic        busy;
    logic [2:0]  fifo_count;
    int          total;
    int          fails;
    logic [63:0] got [$];
    logic [63:0] exp_q [$];

    co_sequencer_if host_if ();

    co_sequencer #(
        .DEPTH   (4),
        .ADD_LAT (1),
        .MUL_LAT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (host_if.slave),
        .proc_out   (proc_out),
        .issue      (issue),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && issue)
            got.push_back(proc_out);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reads carry 1..6, writes 7..9, so consecutive mk words never collide.
    function automatic logic [63:0] mk(input logic [2:0] op,
                                       input logic [7:0] tag);
        logic [63:0] w;
        w        = '0;
        w[2:0]   = op;
        w[13:9]  = 5'd1;
        w[18:14] = 5'd2;
        w[23:19] = 5'd3;
        w[28:24] = 5'd4;
        w[33:29] = 5'd5;
        w[38:34] = 5'd6;
        w[43:39] = 5'd7;
        w[48:44] = 5'd8;
        w[53:49] = 5'd9;
        w[63:56] = tag;
        return w;
    endfunction

    task automatic push(input logic [63:0] w);
        int n;
        host_if.instr_in    = w;
        host_if.instr_valid = 1'b1;
        n = 0;
        while (!host_if.instr_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50)
            chk("ready_wait", {63'd0, host_if.instr_ready}, 64'd1);
        step();
        host_if.instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("drain_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        total = 0;
        fails = 0;
        rst = 1'b1;
        host_if.instr_in    = 64'h0000_0000_0000_0209;
        host_if.instr_valid = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", {63'd0, host_if.instr_ready}, 64'd0);
            chk("rst_proc", proc_out, 64'd0);
            chk("rst_count", {61'd0, fifo_count}, 64'd0);
        end
        rst = 1'b0;
        host_if.instr_valid = 1'b0;
        step();
        chk("post_rst_count", {61'd0, fifo_count}, 64'd0);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_issue", {63'd0, issue}, 64'd0);

        // Single add word
        host_if.instr_in    = 64'h0000_0000_0000_0209;
        host_if.instr_valid = 1'b1;
        step();
        host_if.instr_valid = 1'b0;
        chk("add_queued", {61'd0, fifo_count}, 64'd1);
        chk("add_not_yet", proc_out, 64'd0);
        step();
        chk("add_proc", proc_out, 64'h0000_0000_0000_0209);
        chk("add_issue", {63'd0, issue}, 64'd1);
        step();
        chk("add_after", proc_out, 64'd0);
        chk("add_busy", {63'd0, busy}, 64'd0);
        chk("add_issue_off", {63'd0, issue}, 64'd0);

        // Multiply hold then add
        a = mk(3'b101, 8'hA1);
        b = mk(3'b001, 8'hB1);
        host_if.instr_in    = a;
        host_if.instr_valid = 1'b1;
        step();
        host_if.instr_in = b;
        step();
        host_if.instr_valid = 1'b0;
        chk("mul_proc0", proc_out, a);
        chk("mul_issue0", {63'd0, issue}, 64'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("mul_hold", proc_out, a);
            chk("mul_hold_issue", {63'd0, issue}, 64'd0);
        end
        step();
        chk("mul_next", proc_out, b);
        chk("mul_next_issue", {63'd0, issue}, 64'd1);
        step();
        chk("mul_end", proc_out, 64'd0);
        chk("mul_end_busy", {63'd0, busy}, 64'd0);

        // Full FIFO behind a multiply hold
        got.delete();
        exp_q.delete();
        exp_q.push_back(mk(3'b101, 8'h10));
        for (int i = 1; i <= 5; i++)
            exp_q.push_back(mk(3'b001, 8'(8'h10 + i)));
        push(exp_q[0]);
        for (int i = 1; i <= 4; i++)
            push(exp_q[i]);
        chk("full_count", {61'd0, fifo_count}, 64'd4);
        chk("full_ready", {63'd0, host_if.instr_ready}, 64'd0);
        push(exp_q[5]);
        drain();
        chk("full_issued", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            chk("full_order", (i < got.size()) ? got[i] : 64'hX, exp_q[i]);

        // Reset mid-HOLD with three words queued
        got.delete();
        push(mk(3'b101, 8'h20));
        push(mk(3'b001, 8'h21));
        push(mk(3'b001, 8'h22));
        push(mk(3'b001, 8'h23));
        chk("mid_queued", {61'd0, fifo_count}, 64'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_proc", proc_out, 64'd0);
        chk("mid_count", {61'd0, fifo_count}, 64'd0);
        for (int i = 0; i < 8; i++)
            step();
        chk("mid_flushed", 64'(got.size()), 64'd1);
        chk("mid_busy", {63'd0, busy}, 64'd0);

        // Read-after-write dependency: A writes 5, B reads 5 via AdR2[1]
        a = mk(3'b001, 8'hC1);
        a[43:39] = 5'd5;
        b = mk(3'b001, 8'hC2);
        host_if.instr_in    = a;
        host_if.instr_valid = 1'b1;
        step();
        host_if.instr_in = b;
        step();
        host_if.instr_valid = 1'b0;
        chk("haz_a", proc_out, a);
        chk("haz_a_issue", {63'd0, issue}, 64'd1);
        step();
`ifdef CO_SEQ_HAZARD_EN
        chk("haz_gap", proc_out, 64'd0);
        chk("haz_gap_issue", {63'd0, issue}, 64'd0);
        step();
`endif
        chk("haz_b", proc_out, b);
        chk("haz_b_issue", {63'd0, issue}, 64'd1);
        step();
        chk("haz_end", proc_out, 64'd0);
        drain();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
